// File: rtl/ram_dma.sv
// Purpose : block-transfer initiator that owns a single-port synchronous RAM port (FILL / COPY / CHECK).
// Latency : FILL L+1 cycles, COPY 2L+1, CHECK L+2, zero length or reserved mode 1 cycle to Done_o.
// Backpr. : none; Start_i is ignored while Busy_o=1, and a Start in the DONE cycle chains with no idle cycle.
//
// Ports:
//   Clock, Reset (async active-low)
//   Start_i/Mode_i/SrcAddress_i/DstAddress_i/Length_i/Pattern_i : transfer request
//   Busy_o/Done_o/Error_o/ErrorAddress_o                        : status
//   RamReadEnable_o/RamWriteEnable_o/RamAddress_o/RamData_o/RamData_i : RAM master port
module ram_dma #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start_i,
    input  logic [1:0]               Mode_i,
    input  logic [ADDRESS_WIDTH-1:0] SrcAddress_i,
    input  logic [ADDRESS_WIDTH-1:0] DstAddress_i,
    input  logic [ADDRESS_WIDTH:0]   Length_i,
    input  logic [DATA_WIDTH-1:0]    Pattern_i,
    output logic                     Busy_o,
    output logic                     Done_o,
    output logic                     Error_o,
    output logic [ADDRESS_WIDTH-1:0] ErrorAddress_o,
    output logic                     RamReadEnable_o,
    output logic                     RamWriteEnable_o,
    output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
    output logic [DATA_WIDTH-1:0]    RamData_o,
    input  logic [DATA_WIDTH-1:0]    RamData_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_COPY_RD, S_COPY_WR, S_CHECK_RD, S_CHECK_LAST, S_DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH:0] LEN_ONE = (ADDRESS_WIDTH+1)'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] src_q, src_d;
    logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
    logic [ADDRESS_WIDTH:0]   len_q, len_d;
    logic [DATA_WIDTH-1:0]    pattern_q, pattern_d;
    logic                     err_q, err_d;
    logic [ADDRESS_WIDTH-1:0] err_addr_q, err_addr_d;
    // Read data returns one cycle after the read, so the address it came
    // from and a "compare this cycle" flag are carried one cycle behind.
    logic [ADDRESS_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     accept;

    assign accept = Start_i && (state_q == S_IDLE || state_q == S_DONE);

    // State register and datapath registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            pattern_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            cmp_addr_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            pattern_q  <= pattern_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            cmp_addr_q <= cmp_addr_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (Mode_i == 2'd3 || Length_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        unique case (Mode_i)
                            2'd0:    state_d = S_FILL;
                            2'd1:    state_d = S_COPY_RD;
                            default: state_d = S_CHECK_RD;
                        endcase
                    end
                end
            end
            S_FILL:       if (len_q == LEN_ONE) state_d = S_DONE;
            S_COPY_RD:    state_d = S_COPY_WR;
            S_COPY_WR:    state_d = (len_q == LEN_ONE) ? S_DONE : S_COPY_RD;
            S_CHECK_RD:   if (len_q == LEN_ONE) state_d = S_CHECK_LAST;
            S_CHECK_LAST: state_d = S_DONE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: address/count stepping and CHECK compare
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        pattern_d  = pattern_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        cmp_addr_d = src_q;
        rd_pend_d  = (state_q == S_CHECK_RD);
        if (accept) begin
            src_d      = SrcAddress_i;
            dst_d      = DstAddress_i;
            len_d      = Length_i;
            pattern_d  = Pattern_i;
            err_d      = (Mode_i == 2'd3);
            err_addr_d = '0;
        end else begin
            unique case (state_q)
                S_FILL: begin
                    dst_d = dst_q + 1'b1;
                    len_d = len_q - 1'b1;
                end
                S_COPY_WR: begin
                    src_d = src_q + 1'b1;
                    dst_d = dst_q + 1'b1;
                    len_d = len_q - 1'b1;
                end
                S_CHECK_RD: begin
                    src_d = src_q + 1'b1;
                    len_d = len_q - 1'b1;
                end
                default: ;
            endcase
            // Only the first mismatch is recorded; the scan still runs to the end.
            if (rd_pend_q && RamData_i != pattern_q && !err_q) begin
                err_d      = 1'b1;
                err_addr_d = cmp_addr_q;
            end
        end
    end

    // Output decode
    always_comb begin
        Busy_o           = 1'b0;
        Done_o           = 1'b0;
        RamReadEnable_o  = 1'b0;
        RamWriteEnable_o = 1'b0;
        RamAddress_o     = '0;
        RamData_o        = '0;
        unique case (state_q)
            S_FILL: begin
                Busy_o           = 1'b1;
                RamWriteEnable_o = 1'b1;
                RamAddress_o     = dst_q;
                RamData_o        = pattern_q;
            end
            S_COPY_RD: begin
                Busy_o          = 1'b1;
                RamReadEnable_o = 1'b1;
                RamAddress_o    = src_q;
            end
            S_COPY_WR: begin
                Busy_o           = 1'b1;
                RamWriteEnable_o = 1'b1;
                RamAddress_o     = dst_q;
                RamData_o        = RamData_i;
            end
            S_CHECK_RD: begin
                Busy_o          = 1'b1;
                RamReadEnable_o = 1'b1;
                RamAddress_o    = src_q;
            end
            S_CHECK_LAST: Busy_o = 1'b1;
            S_DONE:       Done_o = 1'b1;
            default: ;
        endcase
    end

    assign Error_o        = err_q;
    assign ErrorAddress_o = err_addr_q;

endmodule

// File: tb/tb_ram_dma.sv
// Purpose : directed testbench for ram_dma with a behavioural synchronous single-port RAM.
// Latency : checks Done_o cycle and RAM access cycles against hand-computed values.
// Backpr. : n/a.
module tb_ram_dma;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] src, dst;
    logic [AW:0]   len;
    logic [DW-1:0] pat;
    logic          busy, done, err;
    logic [AW-1:0] err_addr;
    logic          re, we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdat, ram_rdat;

    logic [DW-1:0] mem [0:255] = '{default: 8'h00};

    int n_checks = 0;
    int n_fail   = 0;

    int            done_cyc, n_we, n_re, busy_bad, both_bad;
    int            we_cyc [0:63];
    logic [AW-1:0] we_adr [0:63];
    logic [DW-1:0] we_dat [0:63];
    int            re_cyc [0:63];

    always #5 clk = ~clk;

    ram_dma #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clock           (clk),
        .Reset           (rst_n),
        .Start_i         (start),
        .Mode_i          (mode),
        .SrcAddress_i    (src),
        .DstAddress_i    (dst),
        .Length_i        (len),
        .Pattern_i       (pat),
        .Busy_o          (busy),
        .Done_o          (done),
        .Error_o         (err),
        .ErrorAddress_o  (err_addr),
        .RamReadEnable_o (re),
        .RamWriteEnable_o(we),
        .RamAddress_o    (ram_addr),
        .RamData_o       (ram_wdat),
        .RamData_i       (ram_rdat)
    );

    // Synchronous RAM with registered read data
    always @(posedge clk) begin
        if (we) mem[ram_addr] <= ram_wdat;
        if (re) ram_rdat <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge (cycle 1).
    task automatic start_xfer(input logic [1:0] m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                              input logic [AW:0] l, input logic [DW-1:0] p);
        mode  = m;
        src   = s;
        dst   = d;
        len   = l;
        pat   = p;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records RAM activity from cycle 'first' until Done_o or the cycle budget.
    task automatic trace(input int first, input int maxc);
        done_cyc = 0; n_we = 0; n_re = 0; busy_bad = 0; both_bad = 0;
        for (int c = first; c <= maxc; c++) begin
            if (we && n_we < 64) begin
                we_cyc[n_we] = c; we_adr[n_we] = ram_addr; we_dat[n_we] = ram_wdat; n_we++;
            end
            if (re && n_re < 64) begin
                re_cyc[n_re] = c; n_re++;
            end
            if (re && we) both_bad++;
            if (done) begin
                done_cyc = c;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [AW-1:0] d, input logic [AW:0] l, input logic [DW-1:0] p);
        start_xfer(2'd0, 8'h00, d, l, p);
        trace(1, 300);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = '0; src = '0; dst = '0; len = '0; pat = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {busy, done, err, err_addr, re, we, ram_addr, ram_wdat}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        idle();

        // FILL 0x10..0x13 with A5
        start_xfer(2'd0, 8'h00, 8'h10, 9'd4, 8'hA5);
        trace(1, 20);
        check_eq("fill_done_cyc", done_cyc, 5);
        check_eq("fill_n_we", n_we, 4);
        check_eq("fill_n_re", n_re, 0);
        check_eq("fill_busy", busy_bad, 0);
        check_eq("fill_first_we_cyc", we_cyc[0], 1);
        for (int i = 0; i < 4; i++) begin
            check_eq("fill_adr", we_adr[i], 8'h10 + i);
            check_eq("fill_dat", we_dat[i], 8'hA5);
        end
        idle();
        check_eq("fill_mem", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hA5A5A5A5);

        // Start while busy: held for cycles 1..3 with other parameters, must be ignored
        start_xfer(2'd0, 8'h00, 8'h60, 9'd6, 8'h3C);
        mode = 2'd0; dst = 8'h90; len = 9'd2; pat = 8'hFF; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            check_eq("busy_ign_adr", ram_addr, 8'h60 + k - 1);
            idle();
        end
        start = 1'b0;
        trace(4, 20);
        check_eq("busy_ign_done", done_cyc, 7);
        check_eq("busy_ign_n_we", n_we, 3);
        check_eq("busy_ign_last", {we_adr[2], we_dat[2]}, 16'h653C);
        idle();
        check_eq("busy_ign_mem90", mem[8'h90], 8'h00);

        // COPY 0x20..0x22 -> 0x40..0x42
        fill(8'h20, 9'd1, 8'h11);
        fill(8'h21, 9'd1, 8'h22);
        fill(8'h22, 9'd1, 8'h33);
        start_xfer(2'd1, 8'h20, 8'h40, 9'd3, 8'h00);
        trace(1, 30);
        check_eq("copy_done_cyc", done_cyc, 7);
        check_eq("copy_counts", {n_re[7:0], n_we[7:0]}, 16'h0303);
        check_eq("copy_re_cyc", {re_cyc[0][7:0], re_cyc[1][7:0], re_cyc[2][7:0]}, 24'h010305);
        check_eq("copy_we_cyc", {we_cyc[0][7:0], we_cyc[1][7:0], we_cyc[2][7:0]}, 24'h020406);
        check_eq("copy_we_adr_dat", {we_adr[1], we_dat[1]}, 16'h4122);
        check_eq("copy_excl", both_bad, 0);
        check_eq("copy_err", err, 1'b0);
        idle();
        check_eq("copy_mem", {mem[8'h40], mem[8'h41], mem[8'h42]}, 24'h112233);

        // CHECK 0x50..0x53 = 5A,5A,00,00 against 5A
        fill(8'h50, 9'd2, 8'h5A);
        fill(8'h52, 9'd2, 8'h00);
        start_xfer(2'd2, 8'h50, 8'h00, 9'd4, 8'h5A);
        trace(1, 30);
        check_eq("check_done_cyc", done_cyc, 6);
        check_eq("check_counts", {n_re[7:0], n_we[7:0]}, 16'h0400);
        check_eq("check_err", err, 1'b1);
        check_eq("check_err_addr", err_addr, 8'h52);
        idle();

        // FILL across the top of the address space
        start_xfer(2'd0, 8'h00, 8'hFE, 9'd4, 8'h77);
        check_eq("wrap_err_cleared", {err, err_addr}, 9'h000);
        trace(1, 20);
        check_eq("wrap_done_cyc", done_cyc, 5);
        check_eq("wrap_adrs", {we_adr[0], we_adr[1], we_adr[2], we_adr[3]}, 32'hFEFF0001);
        idle();

        // Zero length
        start_xfer(2'd0, 8'h00, 8'h70, 9'd0, 8'hEE);
        trace(1, 10);
        check_eq("len0_done_cyc", done_cyc, 1);
        check_eq("len0_access", {n_re[7:0], n_we[7:0], 7'd0, err}, 24'h0);
        idle();

        // Reserved mode, then a FILL accepted in its DONE cycle
        start_xfer(2'd3, 8'h00, 8'h00, 9'd5, 8'h00);
        trace(1, 10);
        check_eq("rsvd_done_cyc", done_cyc, 1);
        check_eq("rsvd_err_access", {n_re[7:0], n_we[7:0], 7'd0, err}, 24'h000001);
        start_xfer(2'd0, 8'h00, 8'hB0, 9'd2, 8'h12);
        check_eq("b2b_err_cleared", err, 1'b0);
        trace(1, 10);
        check_eq("b2b_done_cyc", done_cyc, 3);
        check_eq("b2b_first_we", {we_cyc[0][7:0], we_adr[0]}, 16'h01B0);
        check_eq("b2b_busy", busy_bad, 0);
        idle();

        // Reset during cycle 3 of an 8-word FILL
        start_xfer(2'd0, 8'h00, 8'hC0, 9'd8, 8'h99);
        idle();
        idle();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_outputs", {busy, done, err, err_addr, re, we, ram_addr, ram_wdat}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        idle();
        check_eq("midrst_mem", {mem[8'hC0], mem[8'hC1], mem[8'hC2], mem[8'hC7]}, 32'h99990000);
        start_xfer(2'd0, 8'h00, 8'hD0, 9'd2, 8'h44);
        trace(1, 10);
        check_eq("midrst_refill_done", done_cyc, 3);
        idle();
        check_eq("midrst_refill_mem", {mem[8'hD0], mem[8'hD1]}, 16'h4444);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_dma.md
# ram_dma

Block-transfer initiator that drives the single-port synchronous RAM's read/write port, the master side of that port. It fills an address range with a constant, copies one range to another, or checks a range against a constant. It sits between control logic (CPU bus or sequencer) and one RAM instance, and owns the RAM port for the whole duration of a transfer.

## Interface

**Parameters**
- ADDRESS_WIDTH, default 16: RAM address width.
- DATA_WIDTH, default 8: RAM word width.

**Ports**
- Clock, input, 1: single clock. All state changes on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- Start_i, input, 1: request a transfer. Sampled only while Busy_o=0.
- Mode_i, input, 2: 0=FILL, 1=COPY, 2=CHECK, 3=reserved.
- SrcAddress_i, input, ADDRESS_WIDTH: first address to read (COPY, CHECK).
- DstAddress_i, input, ADDRESS_WIDTH: first address to write (FILL, COPY).
- Length_i, input, ADDRESS_WIDTH+1: number of words, 0 to 2**ADDRESS_WIDTH.
- Pattern_i, input, DATA_WIDTH: fill value (FILL) or expected value (CHECK).
- Busy_o, output, 1: transfer in progress.
- Done_o, output, 1: one-cycle pulse when a transfer completes.
- Error_o, output, 1: sticky flag, set on a CHECK mismatch or a reserved mode.
- ErrorAddress_o, output, ADDRESS_WIDTH: address of the first CHECK mismatch.
- RamReadEnable_o, output, 1: RAM read enable.
- RamWriteEnable_o, output, 1: RAM write enable.
- RamAddress_o, output, ADDRESS_WIDTH: RAM address.
- RamData_o, output, DATA_WIDTH: RAM write data.
- RamData_i, input, DATA_WIDTH: RAM read data. The RAM registers it, so it is valid the cycle after the read enable.

## Operation

- States: IDLE, FILL, COPY_RD, COPY_WR, CHECK_RD, CHECK_LAST, DONE.
- **Start acceptance**
  - Start_i=1 in IDLE or DONE latches Mode_i, SrcAddress_i, DstAddress_i, Length_i and Pattern_i into internal registers.
  - On acceptance: Error_o cleared, ErrorAddress_o cleared to 0.
  - Start_i while Busy_o=1 is ignored; the latched parameters are unchanged.
- **Special cases at start**
  - Length_i=0 → DONE directly, no RAM access.
  - Mode 3 → DONE directly, Error_o=1.
- **FILL**
  - Per word: WE=1, address=dst, data=Pattern.
  - dst increments; remaining count decrements. Exit to DONE when the count reaches 0.
- **COPY**
  - COPY_RD: RE=1, address=src.
  - COPY_WR: WE=1, address=dst, RamData_o=RamData_i (combinational pass-through).
  - Both addresses increment after the write. Transfer order is strictly forward.
  - Overlapping ranges with dst > src propagate already-copied data. This is defined behaviour, not guarded.
- **CHECK**
  - CHECK_RD issues RE=1 at consecutive src addresses, one per cycle.
  - Each returned word is compared to Pattern the following cycle. CHECK_LAST compares the final word.
  - First mismatch: Error_o=1 and ErrorAddress_o=that address. Later mismatches do not overwrite ErrorAddress_o. Checking always runs to the end.
- **DONE**
  - Lasts one cycle with Done_o=1, then IDLE, unless a new Start is accepted.
- **Arithmetic and RAM-side outputs**
  - All address arithmetic is modulo 2**ADDRESS_WIDTH; a range wraps from max to 0.
  - RAM-side outputs are decoded from state and registers. RE and WE are never both 1.
  - Outside active states: RE=0, WE=0, address=0, data=0.
- **Reset**
  - Reset=0 at any time, including mid-transfer: IDLE, all outputs 0, latched parameters 0.
  - Words already written stay written.

## Timing

- Cycle n is the clock period after the n-th rising edge; Start_i is accepted at edge 0.
- Busy_o=1 from cycle 1 until the cycle before DONE. Done_o=1 and Busy_o=0 in the DONE cycle.
- FILL, L words: writes in cycles 1..L; DONE in cycle L+1.
- COPY, L words:
  - Reads in cycles 1,3,…,2L−1; writes in cycles 2,4,…,2L.
  - DONE in cycle 2L+1.
- CHECK, L words:
  - Reads in cycles 1..L; compares in cycles 2..L+1.
  - Error_o/ErrorAddress_o update at the end of the compare cycle.
  - DONE in cycle L+2.
- Length 0 or mode 3: DONE in cycle 1.
- A Start accepted in the DONE cycle begins the next transfer with no idle cycle.
- Throughput: 1 word/cycle for FILL and CHECK, 1 word per 2 cycles for COPY.

## Test plan

- **Fill:** FILL dst=0x0010, L=4, Pattern=0xA5 → WE in cycles 1–4 at 0x10–0x13 with data 0xA5, Done_o in cycle 5, RAM reads back 0xA5 at all four addresses.
- **Copy:** RAM 0x20–0x22 = 11,22,33; COPY src=0x20, dst=0x40, L=3 → 0x40–0x42 = 11,22,33, Done_o in cycle 7, Error_o=0.
- **Check mismatch:** 0x50–0x53 = 5A,5A,00,00; CHECK src=0x50, L=4, Pattern=0x5A → Error_o=1, ErrorAddress_o=0x52, Done_o in cycle 6.
- **Wrap and edge cases** (ADDRESS_WIDTH=4):
  - FILL dst=0xE, L=4 → writes at 0xE, 0xF, 0x0, 0x1.
  - L=0 → Done_o in cycle 1, no RE/WE.
  - Mode 3 → Done_o in cycle 1, Error_o=1.
- **Start while busy / back-to-back:** Start during a busy FILL → ignored, no change. A second Start in the DONE cycle → Busy_o stays low only in that cycle and the transfer begins in the next.
- **Reset mid-transfer:** Reset low during cycle 3 of an 8-word FILL → all outputs 0 immediately. Only the first 2 words are written. After release, a new FILL runs normally.
